run_controller: RTL and testbench

RUN_CONTROLLER -- requirements
Module: run_controller

---
 rtl/run_controller.sv | 159 +++++++++++++++
 tb/tb_run_controller.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_controller.sv
// Run sequencer: holds the CPU in reset after start, runs it, and stops on PC halt or cycle-limit timeout.
// Optional halt detection is compiled in with RUN_CONTROLLER_HALT_DETECT_EN.
module run_controller #(
    parameter int RESET_CYCLES = 4,
    parameter int MAX_CYCLES   = 250,
    parameter int CNT_WIDTH    = 32,
    parameter int PC_WIDTH     = 27,
    parameter int HALT_WINDOW  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [PC_WIDTH-1:0]  pc,
    input  logic                 pc_valid,
    output logic                 cpu_reset,
    output logic                 running,
    output logic                 done,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] cycle_count
);
    // state        | meaning
    // S_IDLE       | waiting for start, CPU held in reset
    // S_RESET_HOLD | CPU held in reset for RESET_CYCLES cycles
    // S_RUN        | CPU released, counting cycles and watching pc
    // S_HALTED     | pc stayed put for HALT_WINDOW valid cycles (sticky)
    // S_TIMEOUT    | MAX_CYCLES run cycles elapsed without halt (sticky)
    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET_HOLD,
        S_RUN,
        S_HALTED,
        S_TIMEOUT
    } state_t;

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]    HOLD_LOAD = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(MAX_CYCLES - 1);

    state_t               state_q, state_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 cpu_reset_q, cpu_reset_d;
    logic                 running_q, running_d;
    logic                 done_q, done_d;
    logic                 timeout_q, timeout_d;
    logic                 start_accept;
    logic                 halt_hit;

    assign start_accept = start && (state_q == S_IDLE || state_q == S_HALTED ||
                                    state_q == S_TIMEOUT);

`ifdef RUN_CONTROLLER_HALT_DETECT_EN
    localparam int MATCH_W = $clog2(HALT_WINDOW + 1);

    logic [PC_WIDTH-1:0] last_pc_q, last_pc_d;
    logic                seeded_q, seeded_d;
    logic [MATCH_W-1:0]  match_q, match_d;

    // seeded_q keeps the first valid pc of a run from matching a stale last_pc
    always_comb begin
        last_pc_d = last_pc_q;
        seeded_d  = seeded_q;
        match_d   = match_q;
        halt_hit  = 1'b0;
        if (start_accept) begin
            last_pc_d = '0;
            seeded_d  = 1'b0;
            match_d   = '0;
        end else if (state_q == S_RUN && pc_valid) begin
            if (seeded_q && pc == last_pc_q) begin
                match_d = match_q + MATCH_W'(1);
            end else begin
                last_pc_d = pc;
                seeded_d  = 1'b1;
                match_d   = MATCH_W'(1);
            end
            halt_hit = (match_d == MATCH_W'(HALT_WINDOW));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_pc_q <= '0;
            seeded_q  <= 1'b0;
            match_q   <= '0;
        end else begin
            last_pc_q <= last_pc_d;
            seeded_q  <= seeded_d;
            match_q   <= match_d;
        end
    end
`else
    logic unused_pc_inputs;
    assign unused_pc_inputs = ^{pc, pc_valid};
    assign halt_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        count_d = count_q;
        case (state_q)
            S_IDLE, S_HALTED, S_TIMEOUT: begin
                if (start_accept) begin
                    state_d = S_RESET_HOLD;
                    hold_d  = HOLD_LOAD;
                    count_d = '0;
                end
            end
            S_RESET_HOLD: begin
                if (hold_q == '0) state_d = S_RUN;
                else              hold_d  = hold_q - HOLD_W'(1);
            end
            S_RUN: begin
                // halt wins over a coincident timeout and freezes the count as-is
                if (halt_hit) begin
                    state_d = S_HALTED;
                end else begin
                    if (count_q != CNT_MAX) count_d = count_q + CNT_WIDTH'(1);
                    if (count_q == CNT_LAST) state_d = S_TIMEOUT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        cpu_reset_d = (state_d != S_RUN);
        running_d   = (state_d == S_RUN);
        done_d      = (state_d == S_HALTED);
        timeout_d   = (state_d == S_TIMEOUT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            count_q     <= '0;
            cpu_reset_q <= 1'b1;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            count_q     <= count_d;
            cpu_reset_q <= cpu_reset_d;
            running_q   <= running_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    assign cpu_reset   = cpu_reset_q;
    assign running     = running_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign cycle_count = count_q;

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: two instances (MAX_CYCLES 250 and 8) checked every cycle against a run-level model.
module tb_run_controller;
    localparam int RC  = 4;
    localparam int HW  = 8;
    localparam int PCW = 27;
    localparam int CW  = 32;
`ifdef RUN_CONTROLLER_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic [1:0]     start, pv;
    logic [PCW-1:0] pc0, pc1;
    logic [1:0]     cpu_reset, running, done, timeout;
    logic [CW-1:0]  cnt0, cnt1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    run_controller u_dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .pc(pc0), .pc_valid(pv[0]),
        .cpu_reset(cpu_reset[0]), .running(running[0]), .done(done[0]),
        .timeout(timeout[0]), .cycle_count(cnt0)
    );

    run_controller #(.MAX_CYCLES(8)) u_dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .pc(pc1), .pc_valid(pv[1]),
        .cpu_reset(cpu_reset[1]), .running(running[1]), .done(done[1]),
        .timeout(timeout[1]), .cycle_count(cnt1)
    );

    // model: busy = a run was started; end 0 none, 1 halted, 2 timed out
    bit             m_busy [2];
    int             m_end  [2];
    int             m_hold [2];
    longint         m_cnt  [2];
    bit             m_have [2];
    int             m_match[2];
    logic [PCW-1:0] m_last [2];
    int             pc_ctr = 0;

    function automatic longint maxc(input int i);
        return (i == 0) ? 250 : 8;
    endfunction

    function automatic bit m_run(input int i);
        return m_busy[i] && m_end[i] == 0 && m_hold[i] == 0;
    endfunction

    task automatic m_clear(input int i);
        m_busy[i] = 0; m_end[i] = 0; m_hold[i] = 0; m_cnt[i] = 0;
        m_have[i] = 0; m_match[i] = 0; m_last[i] = '0;
    endtask

    task automatic m_step(input int i, input bit st, input bit v, input logic [PCW-1:0] p);
        bit halt;
        if (!m_busy[i] || m_end[i] != 0) begin
            if (st) begin
                m_busy[i] = 1; m_end[i] = 0; m_hold[i] = RC; m_cnt[i] = 0;
                m_have[i] = 0; m_match[i] = 0;
            end
        end else if (m_hold[i] > 0) begin
            m_hold[i]--;
        end else begin
            halt = 0;
            if (HALT_EN && v) begin
                if (m_have[i] && p == m_last[i]) m_match[i]++;
                else begin m_last[i] = p; m_have[i] = 1; m_match[i] = 1; end
                halt = (m_match[i] == HW);
            end
            if (halt) m_end[i] = 1;
            else begin
                m_cnt[i]++;
                if (m_cnt[i] == maxc(i)) m_end[i] = 2;
            end
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_clear(0);
            m_clear(1);
        end else begin
            m_step(0, start[0], pv[0], pc0);
            m_step(1, start[1], pv[1], pc1);
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("cpu_reset[%0d]", i), 64'(cpu_reset[i]), 64'(!m_run(i)));
            check($sformatf("running[%0d]", i),   64'(running[i]),   64'(m_run(i)));
            check($sformatf("done[%0d]", i),      64'(done[i]),      64'(m_end[i] == 1));
            check($sformatf("timeout[%0d]", i),   64'(timeout[i]),   64'(m_end[i] == 2));
            check($sformatf("cycle_count[%0d]", i), (i == 0) ? 64'(cnt0) : 64'(cnt1),
                  64'(m_cnt[i]));
        end
    end

    // mode selects the pc pattern; r is the run cycle the model says the DUT is in
    task automatic drive(input int i, input int mode);
        longint r;
        logic [PCW-1:0] p;
        bit v;
        r = m_cnt[i];
        p = '0;
        v = 1'b1;
        case (mode)
            0: begin pc_ctr++; p = PCW'(pc_ctr); end
            1: p = (m_run(i) && r >= 10) ? PCW'('h100) : PCW'('h200 + r);
            2: begin v = (r != 12); p = (r >= 5 && r <= 13) ? PCW'('h55) : PCW'('h1000 + r); end
            3: p = (r >= 5 && r <= 11) ? PCW'('h55) : (r == 12) ? PCW'('h66) : PCW'('h1000 + r);
            4: begin v = ($urandom_range(0, 3) != 0); p = PCW'($urandom_range(0, 1)); end
            default: p = PCW'('h7);
        endcase
        if (i == 0) begin pc0 = p; pv[0] = v; end
        else        begin pc1 = p; pv[1] = v; end
    endtask

    task automatic start_pulse(input int i);
        @(negedge clk);
        start[i] = 1'b1;
        pv[i]    = 1'b0;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    task automatic run_to_end(input int i, input int mode, input int budget);
        bit ended;
        ended = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done[i] || timeout[i]) begin ended = 1; break; end
            drive(i, mode);
        end
        n_cmp++;
        if (!ended) begin
            n_bad++;
            $display("FAIL run_end[%0d] mode %0d: no done/timeout within %0d cycles", i, mode, budget);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        bit hit;
        reset = 1'b1;
        start = '0;
        pv    = '0;
        pc0   = '0;
        pc1   = '0;
        #1;
        check("por cpu_reset", 64'(cpu_reset[0]), 64'd1);
        check("por running",   64'(running[0]),   64'd0);
        check("por done",      64'(done[0]),      64'd0);
        check("por timeout",   64'(timeout[0]),   64'd0);
        check("por count",     64'(cnt0),         64'd0);

        // start sampled on the third edge after reset release
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);
        start[0] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start[0] = 1'b0;
            if (k <= 4) begin
                check($sformatf("hold%0d cpu_reset", k), 64'(cpu_reset[0]), 64'd1);
                check($sformatf("hold%0d running", k),   64'(running[0]),   64'd0);
            end else begin
                check("run0 running",   64'(running[0]),   64'd1);
                check("run0 cpu_reset", 64'(cpu_reset[0]), 64'd0);
                check("run0 count",     64'(cnt0),         64'd0);
            end
            drive(0, 0);
        end
        run_to_end(0, 0, 300);
        check("to timeout",   64'(timeout[0]),   64'd1);
        check("to count",     64'(cnt0),         64'd250);
        check("to cpu_reset", 64'(cpu_reset[0]), 64'd1);

        start_pulse(0);
        run_to_end(0, 1, 300);
        if (HALT_EN) begin
            check("halt done",  64'(done[0]), 64'd1);
            check("halt count", 64'(cnt0),    64'd17);
        end else begin
            check("nohalt timeout", 64'(timeout[0]), 64'd1);
        end

        start_pulse(0);
        run_to_end(0, 2, 300);
        if (HALT_EN) begin
            check("gap done",  64'(done[0]), 64'd1);
            check("gap count", 64'(cnt0),    64'd13);
        end

        start_pulse(0);
        run_to_end(0, 3, 300);
        check("break done",    64'(done[0]),    64'd0);
        check("break timeout", 64'(timeout[0]), 64'd1);

        start_pulse(1);
        run_to_end(1, 5, 40);
        if (HALT_EN) begin
            check("tie done",    64'(done[1]),    64'd1);
            check("tie timeout", 64'(timeout[1]), 64'd0);
            check("tie count",   64'(cnt1),       64'd7);
        end else begin
            check("tie timeout", 64'(timeout[1]), 64'd1);
            check("tie count",   64'(cnt1),       64'd8);
        end
        pv[1] = 1'b0;

        // reset mid-run, then a fresh run
        start_pulse(0);
        hit = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (cnt0 == 32'd40) begin hit = 1; break; end
            drive(0, 0);
        end
        check("reach cycle 40", 64'(hit), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("async cpu_reset", 64'(cpu_reset[0]), 64'd1);
        check("async running",   64'(running[0]),   64'd0);
        check("async count",     64'(cnt0),         64'd0);
        @(negedge clk); #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("post cpu_reset", 64'(cpu_reset[0]), 64'd1);
        check("post running",   64'(running[0]),   64'd0);
        start_pulse(0);
        repeat (4) @(negedge clk);
        check("rerun running", 64'(running[0]), 64'd1);
        check("rerun count",   64'(cnt0),       64'd0);

        // random pc, random restarts and occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start[0] = ($urandom_range(0, 29) == 0);
            drive(0, 4);
            if ($urandom_range(0, 399) == 0) begin
                #1 reset = 1'b1;
                @(negedge clk);
                #1 reset = 1'b0;
            end
        end
        start[0] = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
